// File: rtl/uart_fifo_ctrl.sv
// uart_fifo_ctrl: pointer, occupancy and flag controller that turns the
// dual-port UART RAM into a FIFO. The RAM has a registered read port, so
// rd_valid is a one-cycle-delayed copy of an accepted pop and lines up with
// the RAM's rdata. One instance serves the TX path and one the RX path.
//
// Handshake: wr_req/rd_req are requests, not valid/ready pairs. A push is
// accepted (push_ok) when there is room, or when a pop in the same cycle
// frees a slot. A pop is accepted (pop_ok) whenever the FIFO is not empty.
// A rejected request is dropped and recorded in the sticky overflow or
// underflow flag. There is no back-pressure beyond full/empty, and the
// consumer cannot stall rd_valid.
module uart_fifo_ctrl #(
  parameter int ADDR_BIT = 4,
  parameter int AF_THR   = 12,
  parameter int AE_THR   = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                wr_req,
  input  logic                rd_req,
  input  logic                err_clr,
  output logic                we,
  output logic [ADDR_BIT-1:0] waddr,
  output logic [ADDR_BIT-1:0] raddr,
  output logic                rd_valid,
  output logic [ADDR_BIT:0]   count,
  output logic                full,
  output logic                empty,
  output logic                almost_full,
  output logic                almost_empty,
  output logic                overflow,
  output logic                underflow
);

  localparam logic [ADDR_BIT:0]   DEPTH_C = {1'b1, {ADDR_BIT{1'b0}}};
  localparam logic [ADDR_BIT:0]   AF_C    = (ADDR_BIT+1)'(AF_THR);
  localparam logic [ADDR_BIT:0]   AE_C    = (ADDR_BIT+1)'(AE_THR);
  localparam logic [ADDR_BIT-1:0] PTR_ONE = {{(ADDR_BIT-1){1'b0}}, 1'b1};
  localparam logic [ADDR_BIT:0]   CNT_ONE = {{ADDR_BIT{1'b0}}, 1'b1};

  logic [ADDR_BIT-1:0] wr_ptr;
  logic [ADDR_BIT-1:0] rd_ptr;
  logic                push_ok;
  logic                pop_ok;

  // Flags decode the count register only; the pointers wrap freely and are
  // never compared with each other.
  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  // Acceptance decode: at full, a simultaneous pop makes room for the push.
  // The RAM returns old data on a same-address read/write, so this is safe.
  always_comb begin
    pop_ok  = rd_req && !empty;
    push_ok = wr_req && (!full || pop_ok);
    we      = push_ok && !flush && !reset;
    waddr   = wr_ptr;
    raddr   = rd_ptr;
  end

  // Pointer, occupancy, read-valid and sticky error state; reset beats flush,
  // flush beats any request in the same cycle.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rd_valid  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push_ok && !pop_ok)      count <= count + CNT_ONE;
      else if (pop_ok && !push_ok) count <= count - CNT_ONE;
      rd_valid  <= pop_ok;
      // A new error in the same cycle as err_clr keeps the flag set.
      overflow  <= (wr_req && !push_ok) || (overflow && !err_clr);
      underflow <= (rd_req && !pop_ok)  || (underflow && !err_clr);
    end
  end

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Testbench for uart_fifo_ctrl with a behavioural registered-read RAM
// attached, so data ordering through the FIFO is checked end to end.
module tb_uart_fifo_ctrl;

  localparam int ADDR_BIT = 4;
  localparam int DEPTH    = 16;
  localparam int AF_THR   = 12;
  localparam int AE_THR   = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                reset, flush, wr_req, rd_req, err_clr;
  logic                we, rd_valid, full, empty, almost_full, almost_empty;
  logic                overflow, underflow;
  logic [ADDR_BIT-1:0] waddr, raddr;
  logic [ADDR_BIT:0]   count;
  logic [7:0]          wdata, rdata;
  logic [7:0]          mem [DEPTH];

  uart_fifo_ctrl #(.ADDR_BIT(ADDR_BIT), .AF_THR(AF_THR), .AE_THR(AE_THR)) dut (
    .clk(clk), .reset(reset), .flush(flush), .wr_req(wr_req), .rd_req(rd_req),
    .err_clr(err_clr), .we(we), .waddr(waddr), .raddr(raddr), .rd_valid(rd_valid),
    .count(count), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .overflow(overflow), .underflow(underflow)
  );

  // Registered-read RAM returning old data on same-address read/write.
  always @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

  // ---------------- reference model + scoreboard ----------------
  logic [7:0] exp_q[$];
  int  m_count, m_wr, m_rd;
  bit  m_ovf, m_unf, m_rdv;
  int  n_checks = 0;
  int  n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_count = 0; m_wr = 0; m_rd = 0;
    m_ovf = 0; m_unf = 0; m_rdv = 0;
    exp_q.delete();
  endtask

  // Compare every visible output against the model at the falling edge.
  task automatic check_state();
    chk("count",        32'(count),        32'(m_count));
    chk("full",         32'(full),         32'(m_count == DEPTH));
    chk("empty",        32'(empty),        32'(m_count == 0));
    chk("almost_full",  32'(almost_full),  32'(m_count >= AF_THR));
    chk("almost_empty", 32'(almost_empty), 32'(m_count <= AE_THR));
    chk("overflow",     32'(overflow),     32'(m_ovf));
    chk("underflow",    32'(underflow),    32'(m_unf));
    chk("rd_valid",     32'(rd_valid),     32'(m_rdv));
    chk("waddr",        32'(waddr),        32'(m_wr));
    chk("raddr",        32'(raddr),        32'(m_rd));
    if (rd_valid === 1'b1) begin
      if (exp_q.size() == 0) chk("sb_underrun", 32'(exp_q.size()), 32'd1);
      else chk("rdata", 32'(rdata), 32'(exp_q.pop_front()));
    end
  endtask

  // ---------------- driver ----------------
  // One clock cycle: drive requests, check at negedge, advance the model at posedge.
  task automatic step(input bit w, input bit r, input bit c, input bit f);
    bit m_pop, m_push;
    logic [7:0] d;
    d = 8'($urandom_range(0, 255));
    wr_req = w; rd_req = r; err_clr = c; flush = f; wdata = d;
    @(negedge clk);
    check_state();
    m_pop  = r && (m_count != 0);
    m_push = w && ((m_count != DEPTH) || m_pop);
    chk("we", 32'(we), 32'(m_push && !f));
    @(posedge clk);
    #1;
    if (f) begin
      model_clear();
    end else begin
      if (m_push) begin
        exp_q.push_back(d);
        m_wr = (m_wr + 1) % DEPTH;
      end
      if (m_pop) m_rd = (m_rd + 1) % DEPTH;
      if (m_push && !m_pop) m_count++;
      if (m_pop && !m_push) m_count--;
      m_rdv = m_pop;
      m_ovf = (w && !m_push) || (m_ovf && !c);
      m_unf = (r && !m_pop)  || (m_unf && !c);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b1; flush = 1'b0; wr_req = 1'b0; rd_req = 1'b0; err_clr = 1'b0; wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();

    // Idle after reset.
    step(0, 0, 0, 0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_ae",    32'(almost_empty), 32'd1);
    chk("rst_af",    32'(almost_full), 32'd0);

    // Fill to full; almost_full after the 12th push, full after the 16th.
    for (int i = 0; i < DEPTH; i++) begin
      step(1, 0, 0, 0);
      if (i == AF_THR - 2) chk("af_before_12", 32'(almost_full), 32'd0);
      if (i == AF_THR - 1) chk("af_after_12",  32'(almost_full), 32'd1);
    end
    chk("full16", 32'(full), 32'd1);
    step(1, 0, 0, 0);
    chk("ovf17",   32'(overflow), 32'd1);
    chk("count17", 32'(count), 32'd16);

    // Simultaneous push and pop at full: both accepted, rdata = address-0 word.
    step(1, 1, 1, 0);
    chk("fullpp_count", 32'(count), 32'd16);
    chk("fullpp_waddr", 32'(waddr), 32'd1);
    chk("fullpp_raddr", 32'(raddr), 32'd1);
    chk("fullpp_rdv",   32'(rd_valid), 32'd1);

    // Drain back-to-back, then write 5 and pop 5, then one rejected pop.
    for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    chk("empty_after5", 32'(empty), 32'd1);
    chk("unf_6th",      32'(underflow), 32'd1);
    chk("rdv_6th",      32'(rd_valid), 32'd0);

    // Push and pop into empty: push accepted, pop rejected.
    step(0, 0, 1, 0);
    step(1, 1, 0, 0);
    chk("pp_empty_cnt", 32'(count), 32'd1);
    chk("pp_empty_unf", 32'(underflow), 32'd1);
    step(0, 1, 1, 0);

    // 20 pushes interleaved with 20 pops; pointers wrap.
    for (int i = 0; i < 40; i++) step(i % 2 == 0, i % 2 == 1, 0, 0);

    // Random traffic.
    for (int i = 0; i < 200; i++)
      step($urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
           $urandom_range(0, 9) == 0, 1'b0);
    step(0, 0, 0, 0);
    chk("q_vs_count", 32'(count), 32'(exp_q.size()));

    // Flush together with a push from a count of 7, with an error pending.
    step(0, 0, 0, 1);
    step(0, 1, 0, 0);
    for (int i = 0; i < 7; i++) step(1, 0, 0, 0);
    chk("fill7", 32'(count), 32'd7);
    step(1, 0, 0, 1);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_waddr", 32'(waddr), 32'd0);
    chk("flush_raddr", 32'(raddr), 32'd0);
    chk("flush_unf",   32'(underflow), 32'd0);
    chk("flush_ovf",   32'(overflow), 32'd0);

    // err_clr with a simultaneous rejected pop: the new error wins.
    step(0, 1, 1, 0);
    chk("clr_vs_err", 32'(underflow), 32'd1);
    step(0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_fifo_ctrl.md
Name: uart_fifo_ctrl

Overview:
- Pointer/flag controller that turns the dual-port UART RAM into a FIFO.
- Drives the RAM write enable, write address and read address. Tracks occupancy and reports full/empty, almost-full/almost-empty, and sticky error flags.
- Produces `rd_valid`, aligned with the RAM's registered read data (1-cycle read latency).
- One instance sits on the TX path (CPU side pushes, transmitter pops) and one on the RX path (receiver pushes, CPU side pops).

Parameters:
- ADDR_BIT, 4: RAM address width. FIFO depth DEPTH = 2**ADDR_BIT.
- AF_THR, 12: almost_full asserts when count >= AF_THR. Legal range 1..DEPTH.
- AE_THR, 2: almost_empty asserts when count <= AE_THR. Legal range 0..DEPTH-1.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- flush  in  1  synchronous FIFO clear, same effect as reset
- wr_req  in  1  push request; data is presented to the RAM by the producer in the same cycle
- rd_req  in  1  pop request
- err_clr  in  1  clears the overflow and underflow sticky flags
- we  out  1  RAM write enable (combinational)
- waddr  out  ADDR_BIT  RAM write address = wr_ptr
- raddr  out  ADDR_BIT  RAM read address = rd_ptr
- rd_valid  out  1  RAM rdata holds the popped word this cycle
- count  out  ADDR_BIT+1  occupancy, 0..DEPTH
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count >= AF_THR
- almost_empty  out  1  count <= AE_THR
- overflow  out  1  sticky: a push was rejected
- underflow  out  1  sticky: a pop was rejected

Behaviour:
- Internal registers: wr_ptr, rd_ptr (ADDR_BIT each, wrap modulo DEPTH naturally), count (ADDR_BIT+1), rd_valid, overflow, underflow.
- Reset (and flush) values:
  - wr_ptr = rd_ptr = 0, count = 0, rd_valid = 0, overflow = underflow = 0.
  - Flags therefore: empty = 1, full = 0, almost_empty = 1, almost_full = (AF_THR == 0 ? 1 : 0). AF_THR = 0 is illegal, so almost_full resets to 0.
- flush priority:
  - reset > flush > push/pop.
  - During flush, we = 0 and requests in that cycle are discarded without setting error flags.
- pop_ok = rd_req && !empty.
- push_ok = wr_req && (!full || pop_ok).
  - When full, a simultaneous push and pop are both accepted.
  - The RAM returns old data on a same-address read/write, so this is safe.
- Push and pop when empty: the pop is rejected (underflow set) and the push is accepted.
- we = push_ok && !flush && !reset. This is combinational; waddr and raddr come directly from the pointer registers.
- On push_ok: wr_ptr += 1. On pop_ok: rd_ptr += 1.
- count update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on both or neither.
  - Never exceeds DEPTH and never goes below 0.
- Flag timing: full, empty, almost_full and almost_empty are combinational decodes of the count register, so they reflect state after the previous edge.
- Read latency:
  - rd_valid <= pop_ok, registered.
  - The RAM samples raddr (the old rd_ptr) at the same edge, so rdata and rd_valid are valid together exactly 1 cycle after the accepted pop.
  - Back-to-back pops yield back-to-back rd_valid.
- Errors:
  - wr_req && !push_ok sets overflow.
  - rd_req && !pop_ok sets underflow.
  - Both flags hold until err_clr or reset/flush.
  - If err_clr and a new error occur in the same cycle, the new error wins (flag = 1).
- Wrap-around: pointers roll from DEPTH-1 to 0 with no special handling. full/empty come from count only, never from pointer comparison.

Test Plan:
- Reset, then idle → count = 0, empty = 1, full = 0, almost_empty = 1, we = 0, rd_valid = 0, waddr = raddr = 0.
- 16 consecutive pushes (DEPTH = 16) → we high each cycle, waddr 0..15. almost_full rises after the 12th push, full after the 16th. A 17th push → we = 0, overflow = 1, count stays 16.
- From full: push + pop in the same cycle → both accepted, count = 16, wr_ptr = rd_ptr = 1. rd_valid = 1 the next cycle, with rdata = the word written at address 0.
- Write words A0..A4, then pop 5 back-to-back → rd_valid high for 5 consecutive cycles starting 1 cycle after the first pop, with rdata = A0..A4 in order. Then empty = 1. A 6th pop → underflow = 1, rd_valid = 0.
- Push 20 and pop 20 interleaved → pointers wrap past 15 to 0, data order preserved, count never exceeds 16.
- Fill to 7, then flush together with a push → next cycle count = 0, pointers = 0, we was 0 during flush, overflow/underflow = 0. Then err_clr with a simultaneous rejected pop → underflow = 1.
